// File: rtl/v0_unit_dispatch.sv
// ---------------------------------------------------------------------------
// v0_unit_dispatch
//   Issue controller in front of the v0 execution units. Takes one decoded op
//   per input handshake, pulses a one-hot start to the addressed unit, waits
//   for completion (fixed for single-cycle units, u_done for multi-cycle
//   units) and presents the result on a valid/ready output. Only one op is
//   in flight at a time.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
//   are both 1. Once out_valid is raised, out_* stay stable until
//   out_valid & out_ready. in_ready is raised only in IDLE.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   op handshake
//   in_unit, in_inst    target unit id, unit-local opcode
//   in_arg1/arg2/imm    operands; in_immsel picks in_imm (1) or in_arg2 (0)
//   u_start             one-hot start pulse, only during ISSUE
//   u_inst, u_a, u_b    registered opcode/operands to the units
//   u_done, u_res       per-unit completion, shared result bus
//   out_valid/out_ready result handshake
//   out_res, out_unit   result and producing unit
//   out_exc             0 ok, 1 unknown unit, 2 timeout
//   dbg_state           current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)
// ---------------------------------------------------------------------------
module v0_unit_dispatch #(
  parameter logic [15:0] IMPL_MASK  = 16'h3fff,
  parameter logic [15:0] MULTI_MASK = 16'h28b0,
  parameter logic [7:0]  TMO        = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_unit,
  input  logic [3:0]  in_inst,
  input  logic [31:0] in_arg1,
  input  logic [31:0] in_arg2,
  input  logic [31:0] in_imm,
  input  logic        in_immsel,
  output logic [15:0] u_start,
  output logic [3:0]  u_inst,
  output logic [31:0] u_a,
  output logic [31:0] u_b,
  input  logic [15:0] u_done,
  input  logic [31:0] u_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_res,
  output logic [3:0]  out_unit,
  output logic [1:0]  out_exc,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] EXC_OK  = 2'd0;
  localparam logic [1:0] EXC_UNK = 2'd1;
  localparam logic [1:0] EXC_TMO = 2'd2;

  state_e      state_q, state_d;
  logic [3:0]  unit_q, unit_d;
  logic [3:0]  inst_q, inst_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] res_q, res_d;
  logic [1:0]  exc_q, exc_d;
  logic [7:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      unit_q  <= 4'd0;
      inst_q  <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      res_q   <= 32'd0;
      exc_q   <= EXC_OK;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      unit_q  <= unit_d;
      inst_q  <= inst_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unit_d  = unit_q;
    inst_d  = inst_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    exc_d   = exc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unit_d = in_unit;
          inst_d = in_inst;
          a_d    = in_arg1;
          b_d    = in_immsel ? in_imm : in_arg2;
          if (!IMPL_MASK[in_unit]) begin
            // Unknown unit: skip the units entirely and report at once.
            res_d   = 32'd0;
            exc_d   = EXC_UNK;
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (!MULTI_MASK[unit_q]) begin
          // Single-cycle units drive u_res during the start cycle.
          res_d   = u_res;
          exc_d   = EXC_OK;
          state_d = S_DONE;
        end else begin
          cnt_d   = 8'd0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // Completion is checked before the timeout so that a done arriving
        // on the last allowed cycle still counts as success.
        if (u_done[unit_q]) begin
          res_d   = u_res;
          exc_d   = EXC_OK;
          state_d = S_DONE;
        end else if (cnt_q == TMO) begin
          res_d   = 32'd0;
          exc_d   = EXC_TMO;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign u_start   = (state_q == S_ISSUE) ? (16'd1 << unit_q) : 16'd0;
  assign u_inst    = inst_q;
  assign u_a       = a_q;
  assign u_b       = b_q;
  assign out_res   = res_q;
  assign out_unit  = unit_q;
  assign out_exc   = exc_q;
  assign dbg_state = state_q;

endmodule
